bcd_updown_sync_ctr: RTL and testbench
======================================

// Module: bcd_updown_sync_ctr
// PURPOSE
//  Fully synchronous multi-digit BCD counter, counting up or down, with parallel load.
//  Single-clock counterpart to the ripple decade counters in the counter library.
//  Counts DOWN as well as up, so it can serve as countdown timer / reload divider.
//  Sits between control FSMs and display/timer logic.
//  Terminal-count output allows cascading.
// PARAMETERS
//  NDIGITS  2  number of BCD digits (1..8); digit 0 = least significant, q[3:0]
// PORTS
//  clk       in   1          rising-edge clock; sole clock of the block
//  reset     in   1          synchronous, active-high reset
//  en        in   1          count enable; one step per clk while high
//  up_dn     in   1          1 = count up, 0 = count down
//  load      in   1          parallel load strobe
//  load_val  in   4*NDIGITS  BCD value to load
//  q         out  4*NDIGITS  current count, BCD, registered
//  tc        out  1          terminal count, combinational
//  wrap      out  1          registered one-cycle pulse: a wrap-around occurred
//  load_err  out  1          registered one-cycle pulse: a load was rejected
//  seg       out  7*NDIGITS  only with SEG_DECODE_EN; active-low a..g per digit
// BEHAVIOUR
//  - All state changes on rising clk only. No derived clocks. No async paths.
//  - Reset value: q=0, wrap=0, load_err=0, seg=all digits showing "0".
//  - Priority per cycle: reset > load > en. en=0 and load=0: q holds; wrap=0, load_err=0.
//  - Load, all digits of load_val <=9: q<=load_val next cycle; wrap=0.
//  - Load, any digit >9: q unchanged; load_err=1 for exactly one cycle; wrap=0.
//  - Load always overrides counting in the same cycle, even when en=1.
//  - Up count: digit i increments when en and all lower digits ==9.
//  - Up count: a digit at 9 rolls to 0 and carries.
//  - Down count: digit i decrements when en and all lower digits ==0.
//  - Down count: a digit at 0 rolls to 9 and borrows.
//  - Wrap-around: up from all-9s -> all-0s; down from all-0s -> all-9s.
//  - wrap=1 in the cycle after a wrap step.
//  - tc = en & ~load & ((up_dn & q==all-9s) | (~up_dn & q==all-0s)).
//  - tc is high in the cycle whose edge performs the wrap, for cascading into the next en.
//  - Changing up_dn between cycles takes effect on the next enabled step; no extra latency.
//  - Latency: q reflects a load or step one cycle after the sampling edge.
//  - Reset asserted mid-count: q=0 at the next edge regardless of en/load.
//  - After reset deasserts, the first counted step is 0->1 (up) or 0->all-9s (down).
//  - Digits never hold non-BCD codes (10..15) under any input sequence.
// CONFIGURATION
//  SEG_DECODE_EN defined:
//   - seg port present.
//   - Each digit of q is decoded to a 7-segment pattern.
//   - seg is registered, so it lags q by one cycle.
//   - Segment encoding for digits 0..9, active-low:
//     0=7'b1000000 1=7'b1111001 2=7'b0100100 3=7'b0110000 4=7'b0011001
//     5=7'b0010010 6=7'b0000010 7=7'b1111000 8=7'b0000000 9=7'b0010000
//  SEG_DECODE_EN undefined:
//   - seg port and decode logic absent.
//   - All other behaviour identical.
// TESTING (NDIGITS=2)
//  - reset 1 cycle, en=1, up_dn=1, 100 cycles
//    -> q steps 00..99 -> 00; tc high only at q=99; wrap once, cycle after 99->00.
//  - reset, en=1, up_dn=0
//    -> q goes 00->99->98; tc high at q=00; wrap pulses after 00->99.
//  - load=1, load_val=8'h39, en=1 -> q=39 next (no step); then up -> 40; then down -> 39, 38.
//  - load_val=8'h3A, load=1 -> q unchanged, load_err one cycle.
//  - load_val=8'hF5, load=1 -> q unchanged, load_err one cycle.
//  - Count to q=57, assert reset with en=1 and load=1 -> q=00 next edge; wrap=0, load_err=0.
//  - SEG_DECODE_EN, load 8'h42
//    -> one cycle later seg = {7'b0011001, 7'b0100100}; en=0 holds q and seg.

Source files
------------

// File: rtl/bcd_updown_sync_ctr_if.sv
// bcd_updown_sync_ctr_if: control/data bundle of the BCD up/down counter.
// master drives en/up_dn/load/load_val; slave (the counter) returns q/tc/wrap/load_err.
// Optional: SEG_DECODE_EN adds the registered 7-segment bus seg (active-low a..g).
interface bcd_updown_sync_ctr_if #(
  parameter int NDIGITS = 2
);
  logic                   en;
  logic                   up_dn;
  logic                   load;
  logic [4*NDIGITS-1:0]   load_val;
  logic [4*NDIGITS-1:0]   q;
  logic                   tc;
  logic                   wrap;
  logic                   load_err;
`ifdef SEG_DECODE_EN
  logic [7*NDIGITS-1:0]   seg;

  modport master (
    output en, up_dn, load, load_val,
    input  q, tc, wrap, load_err, seg
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output q, tc, wrap, load_err, seg
  );
`else
  modport master (
    output en, up_dn, load, load_val,
    input  q, tc, wrap, load_err
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output q, tc, wrap, load_err
  );
`endif
endinterface

// File: rtl/bcd_updown_sync_ctr.sv
// bcd_updown_sync_ctr: fully synchronous NDIGITS-digit BCD up/down counter
// with validated parallel load, terminal count, wrap and load-error pulses.
//
// Ports:
//   clk    rising-edge clock, sole clock
//   reset  synchronous, active-high
//   bus    slave side of bcd_updown_sync_ctr_if:
//            en, up_dn, load, load_val (in); q, tc, wrap, load_err (out)
//            seg (out, only with SEG_DECODE_EN)
// Build option: define SEG_DECODE_EN for the registered 7-segment outputs.
module bcd_updown_sync_ctr #(
  parameter int NDIGITS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  bcd_updown_sync_ctr_if.slave     bus
);

  localparam int W = 4 * NDIGITS;

  logic [W-1:0]         q_r;
  logic [W-1:0]         q_step;
  logic                 wrap_r;
  logic                 err_r;
  logic                 tc;
  logic                 load_ok;

  logic [NDIGITS-1:0]   dig_max;
  logic [NDIGITS-1:0]   dig_min;
  logic [NDIGITS-1:0]   dig_bad;
  // carry_up[i]: digits below i are all 9
  // borrow_dn[i]: digits below i are all 0
  logic [NDIGITS:0]     carry_up;
  logic [NDIGITS:0]     borrow_dn;

  always_comb begin
    carry_up[0]  = 1'b1;
    borrow_dn[0] = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      carry_up[i+1]  = carry_up[i] & dig_max[i];
      borrow_dn[i+1] = borrow_dn[i] & dig_min[i];
    end
  end

  for (genvar i = 0; i < NDIGITS; i++) begin : g_dig
    logic [3:0] dig;
    logic [3:0] ld_dig;
    logic [3:0] nxt;
    logic       up_step;
    logic       dn_step;

    assign dig        = q_r[4*i +: 4];
    assign ld_dig     = bus.load_val[4*i +: 4];
    assign dig_max[i] = (dig == 4'd9);
    assign dig_min[i] = (dig == 4'd0);
    assign dig_bad[i] = (ld_dig > 4'd9);

    assign up_step =  bus.up_dn & carry_up[i];
    assign dn_step = ~bus.up_dn & borrow_dn[i];

    always_comb begin
      nxt = dig;
      unique case (1'b1)
        up_step: nxt = dig_max[i] ? 4'd0 : dig + 4'd1;
        dn_step: nxt = dig_min[i] ? 4'd9 : dig - 4'd1;
        default: nxt = dig;
      endcase
    end

    assign q_step[4*i +: 4] = nxt;
  end

  assign load_ok = ~|dig_bad;

  // Full-range terminal: also the condition for a wrap step.
  assign tc = bus.en & ~bus.load &
              (( bus.up_dn & carry_up[NDIGITS]) |
               (~bus.up_dn & borrow_dn[NDIGITS]));

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      wrap_r <= tc;
      err_r  <= bus.load & ~load_ok;
      if (bus.load) begin
        if (load_ok) begin
          q_r <= bus.load_val;
        end
      end else if (bus.en) begin
        q_r <= q_step;
      end
    end
  end

  assign bus.q        = q_r;
  assign bus.tc       = tc;
  assign bus.wrap     = wrap_r;
  assign bus.load_err = err_r;

`ifdef SEG_DECODE_EN
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      // q never holds 10..15; blank rather than garbage
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [7*NDIGITS-1:0] seg_r;
  logic [7*NDIGITS-1:0] seg_nxt;

  for (genvar i = 0; i < NDIGITS; i++) begin : g_seg
    assign seg_nxt[7*i +: 7] = seg7(q_r[4*i +: 4]);
  end

  // Decodes the registered q, so seg trails q by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r <= {NDIGITS{SEG_ZERO}};
    end else begin
      seg_r <= seg_nxt;
    end
  end

  assign bus.seg = seg_r;
`endif

endmodule

// File: tb/tb_bcd_updown_sync_ctr.sv
// tb_bcd_updown_sync_ctr: randomized + directed bench for bcd_updown_sync_ctr.
// Reference model keeps the count as a plain integer modulo 10**N.
module tb_bcd_updown_sync_ctr;

  localparam int N   = 2;
  localparam int W   = 4 * N;
  localparam int MOD = 100;

  localparam logic [6:0] SEGTBL [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic clk = 1'b0;
  logic reset;

  bcd_updown_sync_ctr_if #(.NDIGITS(N)) bus ();

  bcd_updown_sync_ctr #(.NDIGITS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int mval;
  int mseg;
  bit mwrap;
  bit mlerr;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [W-1:0] x);
    for (int i = 0; i < N; i++)
      if (x[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] x);
    int v;
    v = 0;
    for (int i = N - 1; i >= 0; i--)
      v = v * 10 + int'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [7*N-1:0] seg_of(input int v);
    logic [7*N-1:0] r;
    int t;
    t = v;
    for (int i = 0; i < N; i++) begin
      r[7*i +: 7] = SEGTBL[t % 10];
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit exp_tc();
    if (!bus.en || bus.load) return 1'b0;
    return bus.up_dn ? (mval == MOD - 1) : (mval == 0);
  endfunction

  task automatic drive(input bit e, input bit u, input bit l,
                       input logic [W-1:0] v);
    bus.en       = e;
    bus.up_dn    = u;
    bus.load     = l;
    bus.load_val = v;
  endtask

  // Advance one clock, updating the model from the currently driven inputs.
  task automatic step();
    if (reset) begin
      mval  = 0;
      mseg  = 0;
      mwrap = 0;
      mlerr = 0;
    end else begin
      mseg  = mval;
      mwrap = exp_tc();
      mlerr = bus.load && !bcd_ok(bus.load_val);
      if (bus.load) begin
        if (bcd_ok(bus.load_val)) mval = from_bcd(bus.load_val);
      end else if (bus.en) begin
        mval = bus.up_dn ? (mval + 1) % MOD : (mval + MOD - 1) % MOD;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, '0);
    step();
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, '0);
    n_cmp++;
    if (bus.q !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_q got %h want 00", bus.q);
    end
    n_cmp++;
    if (bus.wrap !== 1'b0 || bus.load_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pulses got wrap=%b err=%b want 0 0",
               bus.wrap, bus.load_err);
    end
`ifdef SEG_DECODE_EN
    n_cmp++;
    if (bus.seg !== {7'b1000000, 7'b1000000}) begin
      n_bad++;
      $display("FAIL reset_seg got %b want all zeros digit", bus.seg);
    end
`endif
  endtask

  task automatic test_count_up();
    int nwrap;
    int ntc;
    reset = 1'b1;
    step();
    reset = 1'b0;
    nwrap = 0;
    ntc   = 0;
    drive(1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 100; k++) begin
      #1;
      if (bus.tc === 1'b1) ntc++;
      n_cmp++;
      if (bus.tc !== exp_tc()) begin
        n_bad++;
        $display("FAIL up_tc k=%0d got %b want %b", k, bus.tc, exp_tc());
      end
      step();
      if (bus.wrap === 1'b1) nwrap++;
      n_cmp++;
      if (bus.q !== to_bcd(mval) || bus.wrap !== mwrap) begin
        n_bad++;
        $display("FAIL up_step k=%0d got q=%h wrap=%b want q=%h wrap=%b",
                 k, bus.q, bus.wrap, to_bcd(mval), mwrap);
      end
    end
    n_cmp++;
    if (nwrap != 1 || ntc != 1 || bus.q !== 8'h00) begin
      n_bad++;
      $display("FAIL up_summary got wraps=%0d tcs=%0d q=%h want 1 1 00",
               nwrap, ntc, bus.q);
    end
  endtask

  task automatic test_count_down();
    logic [W-1:0] want [3];
    want = '{8'h99, 8'h98, 8'h97};
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0);
    #1;
    n_cmp++;
    if (bus.tc !== 1'b1) begin
      n_bad++;
      $display("FAIL dn_tc_at_00 got %b want 1", bus.tc);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (bus.q !== want[k] || bus.wrap !== (k == 0)) begin
        n_bad++;
        $display("FAIL dn_step k=%0d got q=%h wrap=%b want q=%h wrap=%b",
                 k, bus.q, bus.wrap, want[k], (k == 0));
      end
    end
  endtask

  task automatic test_load();
    logic [W-1:0] want [4];
    want = '{8'h39, 8'h40, 8'h39, 8'h38};
    drive(1'b1, 1'b1, 1'b1, 8'h39);
    #1;
    n_cmp++;
    if (bus.tc !== 1'b0) begin
      n_bad++;
      $display("FAIL load_tc got %b want 0", bus.tc);
    end
    step();
    n_cmp++;
    if (bus.q !== want[0]) begin
      n_bad++;
      $display("FAIL load_q got %h want %h", bus.q, want[0]);
    end
    drive(1'b1, 1'b1, 1'b0, '0);
    step();
    n_cmp++;
    if (bus.q !== want[1]) begin
      n_bad++;
      $display("FAIL load_up got %h want %h", bus.q, want[1]);
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int k = 2; k < 4; k++) begin
      step();
      n_cmp++;
      if (bus.q !== want[k]) begin
        n_bad++;
        $display("FAIL load_dn k=%0d got %h want %h", k, bus.q, want[k]);
      end
    end
  endtask

  task automatic test_load_err();
    logic [W-1:0] bad [2];
    logic [W-1:0] held;
    bad  = '{8'h3A, 8'hF5};
    for (int k = 0; k < 2; k++) begin
      held = bus.q;
      drive(1'b1, 1'b1, 1'b1, bad[k]);
      step();
      n_cmp++;
      if (bus.q !== held || bus.load_err !== 1'b1 || bus.wrap !== 1'b0) begin
        n_bad++;
        $display("FAIL load_err k=%0d got q=%h err=%b wrap=%b want q=%h err=1 wrap=0",
                 k, bus.q, bus.load_err, bus.wrap, held);
      end
      drive(1'b0, 1'b1, 1'b0, '0);
      step();
      n_cmp++;
      if (bus.q !== held || bus.load_err !== 1'b0) begin
        n_bad++;
        $display("FAIL load_err_clr k=%0d got q=%h err=%b want q=%h err=0",
                 k, bus.q, bus.load_err, held);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 1'b1, 8'h56);
    step();
    drive(1'b1, 1'b1, 1'b0, '0);
    step();
    n_cmp++;
    if (bus.q !== 8'h57) begin
      n_bad++;
      $display("FAIL mid_pre got %h want 57", bus.q);
    end
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'hAB);
    step();
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, '0);
    n_cmp++;
    if (bus.q !== 8'h00 || bus.wrap !== 1'b0 || bus.load_err !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset got q=%h wrap=%b err=%b want 00 0 0",
               bus.q, bus.wrap, bus.load_err);
    end
    step();
    n_cmp++;
    if (bus.q !== 8'h01) begin
      n_bad++;
      $display("FAIL mid_first_up got %h want 01", bus.q);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
            W'($urandom));
      // bias toward the terminal values so wraps happen often
      if ($urandom_range(0, 5) == 0) drive(bus.en, bus.up_dn, 1'b1, 8'h99);
      else if ($urandom_range(0, 9) == 0) drive(bus.en, bus.up_dn, 1'b1, 8'h00);
      #1;
      n_cmp++;
      if (bus.tc !== (reset ? bus.tc : exp_tc())) begin
        n_bad++;
        $display("FAIL rnd_tc k=%0d got %b want %b", k, bus.tc, exp_tc());
      end
      step();
      n_cmp++;
      if (bus.q !== to_bcd(mval) || bus.wrap !== mwrap ||
          bus.load_err !== mlerr) begin
        n_bad++;
        $display("FAIL rnd k=%0d got q=%h wrap=%b err=%b want q=%h wrap=%b err=%b",
                 k, bus.q, bus.wrap, bus.load_err, to_bcd(mval), mwrap, mlerr);
      end
      n_cmp++;
      if (!bcd_ok(bus.q)) begin
        n_bad++;
        $display("FAIL rnd_bcd k=%0d got q=%h want BCD digits", k, bus.q);
      end
`ifdef SEG_DECODE_EN
      n_cmp++;
      if (bus.seg !== seg_of(mseg)) begin
        n_bad++;
        $display("FAIL rnd_seg k=%0d got %b want %b", k, bus.seg, seg_of(mseg));
      end
`endif
    end
    reset = 1'b0;
  endtask

`ifdef SEG_DECODE_EN
  task automatic test_seg();
    drive(1'b0, 1'b1, 1'b1, 8'h42);
    step();
    drive(1'b0, 1'b1, 1'b0, '0);
    step();
    n_cmp++;
    if (bus.q !== 8'h42 || bus.seg !== {7'b0011001, 7'b0100100}) begin
      n_bad++;
      $display("FAIL seg_42 got q=%h seg=%b want 42 00110010100100",
               bus.q, bus.seg);
    end
    step();
    n_cmp++;
    if (bus.q !== 8'h42 || bus.seg !== {7'b0011001, 7'b0100100}) begin
      n_bad++;
      $display("FAIL seg_hold got q=%h seg=%b want 42 00110010100100",
               bus.q, bus.seg);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, '0);
    mval  = 0;
    mseg  = 0;
    mwrap = 0;
    mlerr = 0;
    #2;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_load_err();
    test_reset_mid();
`ifdef SEG_DECODE_EN
    test_seg();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
